// File: rtl/sa_cache_pkg.sv
// Shared types and address-field width helpers for the set-associative cache controller.
package sa_cache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } cache_state_t;

    typedef struct packed {
        logic        rw;
        logic [31:0] data;
    } cpu_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] data;
    } cpu_res_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - off_w(line_words) - idx_w(sets);
    endfunction

    // Selector width that never collapses to zero bits.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_cache_way.sv
// One cache way: valid/dirty/tag/data arrays behind a single index port with a
// registered read; a write also updates the read register so a re-compare sees the new line.
module sa_cache_way
    import sa_cache_pkg::*;
#(
    parameter int SETS   = 1024,
    parameter int IDX_W  = 10,
    parameter int TAG_W  = 18,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic              we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_dirty,
    input  logic [LINE_W-1:0] wr_line,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line
);

    logic [SETS-1:0]   valid_a;
    logic [SETS-1:0]   dirty_a;
    logic [TAG_W-1:0]  tag_a  [SETS];
    logic [LINE_W-1:0] line_a [SETS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_a  <= '0;
            dirty_a  <= '0;
            rd_valid <= 1'b0;
            rd_dirty <= 1'b0;
        end else if (we) begin
            valid_a[idx] <= 1'b1;
            dirty_a[idx] <= wr_dirty;
            rd_valid     <= 1'b1;
            rd_dirty     <= wr_dirty;
        end else begin
            rd_valid <= valid_a[idx];
            rd_dirty <= dirty_a[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_a[idx]  <= wr_tag;
            line_a[idx] <= wr_line;
            rd_tag      <= wr_tag;
            rd_line     <= wr_line;
        end else begin
            rd_tag  <= tag_a[idx];
            rd_line <= line_a[idx];
        end
    end

endmodule

// File: rtl/sa_cache_fsm.sv
// Write-back, write-allocate set-associative cache controller with round-robin
// replacement. Handshake: CPU holds cpu_req_valid until the one-cycle cpu_res_ready; we hold mem_req_valid until the one-cycle mem_resp_ready.
module sa_cache_fsm
    import sa_cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 1024,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req_valid,
    input  logic                     cpu_req_rw,
    input  logic [ADDR_W-1:0]        cpu_req_addr,
    input  logic [31:0]              cpu_req_data,
    output logic                     cpu_res_ready,
    output logic [31:0]              cpu_res_data,
    output logic                     mem_req_valid,
    output logic                     mem_req_rw,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [32*LINE_WORDS-1:0] mem_req_data,
    input  logic                     mem_resp_ready,
    input  logic [32*LINE_WORDS-1:0] mem_resp_data,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt,
    output cache_state_t             dbg_state
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int PTR_W  = sel_w(WAYS);
    localparam int WSEL_W = sel_w(LINE_WORDS);
    localparam int LINE_W = 32 * LINE_WORDS;

    cache_state_t      state;
    cpu_req_t          req;
    cpu_res_t          res;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_word;

    logic              way_valid [WAYS];
    logic              way_dirty [WAYS];
    logic [TAG_W-1:0]  way_tag   [WAYS];
    logic [LINE_W-1:0] way_line  [WAYS];
    logic [WAYS-1:0]   way_we;
    logic              wr_dirty;
    logic [LINE_W-1:0] wr_line;

    logic [PTR_W-1:0]  rr_ptr [SETS];
    logic [PTR_W-1:0]  hit_way, victim, vic_r;
    logic              hit, all_valid, vic_full_r, refill_r;
    logic [LINE_W-1:0] hit_line, merged;

    assign req       = '{rw: cpu_req_rw, data: cpu_req_data};
    assign req_idx   = cpu_req_addr[OFF_W +: IDX_W];
    assign req_tag   = cpu_req_addr[ADDR_W-1 -: TAG_W];
    assign req_word  = WSEL_W'((cpu_req_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign dbg_state = state;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        sa_cache_way #(
            .SETS   (SETS),
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .idx      (req_idx),
            .we       (way_we[w]),
            .wr_tag   (req_tag),
            .wr_dirty (wr_dirty),
            .wr_line  (wr_line),
            .rd_valid (way_valid[w]),
            .rd_dirty (way_dirty[w]),
            .rd_tag   (way_tag[w]),
            .rd_line  (way_line[w])
        );
    end

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        all_valid = 1'b1;
        victim    = rr_ptr[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (way_valid[w] && (way_tag[w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = PTR_W'(w);
            end
            if (!way_valid[w]) all_valid = 1'b0;
        end
        // Lowest-index invalid way wins over the round-robin pointer.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim = PTR_W'(w);
        end
        hit_line = way_line[hit_way];
        merged   = hit_line;
        merged[32*req_word +: 32] = req.data;
        res.ready = (state == COMPARE) && hit;
        res.data  = hit_line[32*req_word +: 32];
        way_we   = '0;
        wr_dirty = 1'b0;
        wr_line  = mem_resp_data;
        if ((state == COMPARE) && hit && req.rw) begin
            way_we[hit_way] = 1'b1;
            wr_dirty        = 1'b1;
            wr_line         = merged;
        end else if ((state == ALLOCATE) && mem_resp_ready) begin
            way_we[vic_r] = 1'b1;
        end
    end

    assign cpu_res_ready = res.ready;
    assign cpu_res_data  = res.data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            vic_r         <= '0;
            vic_full_r    <= 1'b0;
            refill_r      <= 1'b0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        state    <= COMPARE;
                        refill_r <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        state <= IDLE;
                        if (!refill_r && (hit_cnt != 32'hFFFF_FFFF)) hit_cnt <= hit_cnt + 32'd1;
                    end else begin
                        if (!refill_r && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
                        vic_r         <= victim;
                        vic_full_r    <= all_valid;
                        mem_req_valid <= 1'b1;
                        if (way_valid[victim] && way_dirty[victim]) begin
                            state        <= WRITE_BACK;
                            mem_req_rw   <= 1'b1;
                            mem_req_addr <= {way_tag[victim], req_idx, {OFF_W{1'b0}}};
                            mem_req_data <= way_line[victim];
                        end else begin
                            state        <= ALLOCATE;
                            mem_req_rw   <= 1'b0;
                            mem_req_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITE_BACK: begin
                    if (mem_resp_ready) begin
                        state        <= ALLOCATE;
                        mem_req_rw   <= 1'b0;
                        mem_req_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (mem_resp_ready) begin
                        state         <= COMPARE;
                        mem_req_valid <= 1'b0;
                        refill_r      <= 1'b1;
                        if (vic_full_r) rr_ptr[req_idx] <= (WAYS == 1) ? '0 : vic_r + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_cache_fsm.sv
// Directed plus randomized checks of sa_cache_fsm (2 ways, 4 sets, 4-word lines)
// against a slot-level cache model and a backing line memory.
`timescale 1ns/1ps
module tb_sa_cache_fsm;
    import sa_cache_pkg::*;

    localparam int WAYS   = 2;
    localparam int SETS   = 4;
    localparam int LW     = 4;
    localparam int AW     = 32;
    localparam int LINE_W = 32 * LW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req_valid = 1'b0;
    logic              cpu_req_rw = 1'b0;
    logic [AW-1:0]     cpu_req_addr = '0;
    logic [31:0]       cpu_req_data = '0;
    logic              cpu_res_ready;
    logic [31:0]       cpu_res_data;
    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [AW-1:0]     mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_resp_ready = 1'b0;
    logic [LINE_W-1:0] mem_resp_data = '0;
    logic [31:0]       hit_cnt, miss_cnt;
    cache_state_t      dbg_state;

    sa_cache_fsm #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_rw     (cpu_req_rw),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_data   (cpu_req_data),
        .cpu_res_ready  (cpu_res_ready),
        .cpu_res_data   (cpu_res_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [32:0]       exp_q[$];
    logic [LINE_W-1:0] exp_wb_q[$];
    logic [32:0]       act_q[$];
    logic [LINE_W-1:0] act_wb_q[$];
    logic [LINE_W-1:0] bmem [logic [31:0]];
    bit                mem_auto = 1'b1;
    logic [31:0]       last_rd;
    int                last_cyc;

    // Reference model: what each set holds, slot by slot.
    bit          m_v    [SETS][WAYS];
    bit          m_d    [SETS][WAYS];
    logic [31:0] m_tag  [SETS][WAYS];
    logic [LINE_W-1:0] m_line [SETS][WAYS];
    int          m_ptr  [SETS];
    logic [31:0] m_hits, m_misses;

    function automatic logic [LINE_W-1:0] dflt(input logic [31:0] a);
        return {a ^ 32'h3C3C_0303, a ^ 32'h3C3C_0202, a ^ 32'h3C3C_0101, a ^ 32'h3C3C_0000};
    endfunction

    function automatic logic [LINE_W-1:0] bmem_get(input logic [31:0] a);
        if (!bmem.exists(a)) bmem[a] = dflt(a);
        return bmem[a];
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_v[s][w] = 1'b0;
                m_d[s][w] = 1'b0;
            end
        end
        m_hits   = '0;
        m_misses = '0;
    endtask

    task automatic model_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] exp_rd, output bit exp_hit);
        int idx, wd, hw, vw;
        logic [31:0] tag, la;
        bit full;
        idx = int'((addr >> 4) & 32'h3);
        wd  = int'((addr >> 2) & 32'h3);
        tag = addr >> 6;
        la  = addr & 32'hFFFF_FFF0;
        hw = -1;
        full = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (m_v[idx][w] && m_tag[idx][w] == tag) hw = w;
            if (!m_v[idx][w]) full = 1'b0;
        end
        exp_hit = (hw >= 0);
        if (hw < 0) begin
            if (m_misses != 32'hFFFF_FFFF) m_misses++;
            vw = m_ptr[idx];
            for (int w = WAYS - 1; w >= 0; w--) if (!m_v[idx][w]) vw = w;
            if (m_v[idx][vw] && m_d[idx][vw]) begin
                exp_q.push_back({1'b1, (m_tag[idx][vw] << 6) | 32'(idx << 4)});
                exp_wb_q.push_back(m_line[idx][vw]);
            end
            exp_q.push_back({1'b0, la});
            m_line[idx][vw] = bmem_get(la);
            m_v[idx][vw]    = 1'b1;
            m_d[idx][vw]    = 1'b0;
            m_tag[idx][vw]  = tag;
            if (full) m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
            hw = vw;
        end else if (m_hits != 32'hFFFF_FFFF) begin
            m_hits++;
        end
        exp_rd = m_line[idx][hw][wd*32 +: 32];
        if (rw) begin
            m_line[idx][hw][wd*32 +: 32] = wdata;
            m_d[idx][hw] = 1'b1;
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (mem_auto && rst && (mem_req_valid === 1'b1)) begin
                act_q.push_back({mem_req_rw, mem_req_addr});
                if (mem_req_rw) begin
                    act_wb_q.push_back(mem_req_data);
                    bmem[mem_req_addr] = mem_req_data;
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                mem_resp_data  = mem_req_rw ? '0 : bmem_get(mem_req_addr);
                mem_resp_ready = 1'b1;
                @(negedge clk);
                mem_resp_ready = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        cpu_req_valid = 1'b0;
        #1;
        chk("rst_state", LINE_W'(dbg_state), LINE_W'(IDLE));
        chk("rst_res_ready", LINE_W'(cpu_res_ready), '0);
        chk("rst_mem_valid", LINE_W'(mem_req_valid), '0);
        chk("rst_hit_cnt", LINE_W'(hit_cnt), '0);
        chk("rst_miss_cnt", LINE_W'(miss_cnt), '0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rd;
        bit exp_hit, seen;
        exp_q.delete(); exp_wb_q.delete(); act_q.delete(); act_wb_q.delete();
        model_access(rw, addr, wdata, exp_rd, exp_hit);
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        cpu_req_data  = wdata;
        seen = 1'b0;
        last_cyc = 0;
        last_rd = '0;
        while (!seen && last_cyc < 300) begin
            @(negedge clk);
            last_cyc++;
            if (cpu_res_ready === 1'b1) begin
                seen = 1'b1;
                last_rd = cpu_res_data;
            end
        end
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        chk("res_ready_seen", LINE_W'(seen), LINE_W'(1'b1));
        if (!rw) chk("read_data", LINE_W'(last_rd), LINE_W'(exp_rd));
        if (exp_hit) chk("hit_latency", LINE_W'(last_cyc), LINE_W'(2));
        chk("mem_req_count", LINE_W'(act_q.size()), LINE_W'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk("mem_req_rw_addr", LINE_W'(act_q[i]), LINE_W'(exp_q[i]));
        for (int i = 0; i < exp_wb_q.size() && i < act_wb_q.size(); i++)
            chk("wb_data", act_wb_q[i], exp_wb_q[i]);
        chk("hit_cnt", LINE_W'(hit_cnt), LINE_W'(m_hits));
        chk("miss_cnt", LINE_W'(miss_cnt), LINE_W'(m_misses));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        bmem[32'h40] = {32'h4, 32'h3, 32'h2, 32'h1};
        model_reset();
        apply_reset();

        // cold miss, then hits on the same line
        do_access(1'b0, 32'h40, '0);
        chk("cold_rd_data", LINE_W'(last_rd), LINE_W'(32'h1));
        chk("cold_miss_cnt", LINE_W'(miss_cnt), LINE_W'(1));
        if (act_q.size() > 0) chk("cold_fill_req", LINE_W'(act_q[0]), LINE_W'({1'b0, 32'h40}));
        do_access(1'b0, 32'h44, '0);
        chk("hit_rd_data", LINE_W'(last_rd), LINE_W'(32'h2));
        chk("hit_latency_2", LINE_W'(last_cyc), LINE_W'(2));
        chk("hit_cnt_1", LINE_W'(hit_cnt), LINE_W'(1));
        chk("hit_no_mem", LINE_W'(act_q.size()), '0);
        do_access(1'b1, 32'h48, 32'hDEAD_BEEF);
        chk("wr_hit_no_mem", LINE_W'(act_q.size()), '0);
        do_access(1'b0, 32'h48, '0);
        chk("wr_then_rd", LINE_W'(last_rd), LINE_W'(32'hDEAD_BEEF));
        chk("wr_rd_no_mem", LINE_W'(act_q.size()), '0);

        // eviction: clean victim first, then dirty victim with write-back
        apply_reset();
        do_access(1'b0, 32'h00, '0);
        do_access(1'b0, 32'h40, '0);
        do_access(1'b1, 32'h40, 32'h1234_5678);
        do_access(1'b0, 32'h80, '0);
        chk("clean_evict_nreq", LINE_W'(act_q.size()), LINE_W'(1));
        if (act_q.size() > 0) chk("clean_evict_fill", LINE_W'(act_q[0]), LINE_W'({1'b0, 32'h80}));
        do_access(1'b0, 32'hC0, '0);
        chk("dirty_evict_nreq", LINE_W'(act_q.size()), LINE_W'(2));
        if (act_q.size() > 1) begin
            chk("dirty_evict_wb", LINE_W'(act_q[0]), LINE_W'({1'b1, 32'h40}));
            chk("dirty_evict_fill", LINE_W'(act_q[1]), LINE_W'({1'b0, 32'hC0}));
        end
        if (act_wb_q.size() > 0)
            chk("dirty_evict_wb_data", act_wb_q[0], {32'h4, 32'h3, 32'h2, 32'h1234_5678});

        // reset while a fill is outstanding
        mem_auto = 1'b0;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = 32'h100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dbg_state !== ALLOCATE && n < 20);
        chk("alloc_reached", LINE_W'(dbg_state), LINE_W'(ALLOCATE));
        chk("alloc_mem_valid", LINE_W'(mem_req_valid), LINE_W'(1'b1));
        chk("alloc_mem_addr", LINE_W'(mem_req_addr), LINE_W'(32'h100));
        #2;
        rst = 1'b0;
        cpu_req_valid = 1'b0;
        #1;
        chk("abort_mem_valid", LINE_W'(mem_req_valid), '0);
        chk("abort_state", LINE_W'(dbg_state), LINE_W'(IDLE));
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_auto = 1'b1;
        do_access(1'b0, 32'h40, '0);
        chk("post_abort_miss", LINE_W'(miss_cnt), LINE_W'(1));
        chk("post_abort_hit", LINE_W'(hit_cnt), '0);

        // randomized traffic over six tags in every set
        for (int i = 0; i < 200; i++) begin
            do_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 95)) << 2, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
